// File: rtl/fp_div.sv
// Sequential bfloat16 divider: restoring mantissa division, one quotient bit per cycle, truncated result.
// Optional FP_DIV_EARLY_OUT_EN: special operands skip DIVIDE and finish with a 2-cycle latency.
module fp_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    output logic [15:0] quotient,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sign_q, sign_d;
    logic [7:0]  ea_q, ea_d;
    logic [7:0]  eb_q, eb_d;
    logic [8:0]  rem_q, rem_d;
    logic [7:0]  dvs_q, dvs_d;
    logic [8:0]  q_q, q_d;
    logic [15:0] quotient_q, quotient_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        inx_q, inx_d;
    logic        dbz_q, dbz_d;

    logic        a_zero, a_inf, b_zero, b_inf;
    logic [8:0]  shifted;
    logic [9:0]  diff;
    logic signed [9:0] e_raw, e_norm;
    logic [6:0]  frac;
    logic        frac_inexact;
    logic        accept;

`ifdef FP_DIV_EARLY_OUT_EN
    function automatic logic is_special(input logic [15:0] a, input logic [15:0] b);
        return (a[14:7] == 8'h00) || (a[14:7] == 8'hFF) ||
               (b[14:7] == 8'h00) || (b[14:7] == 8'hFF);
    endfunction
`endif

    assign a_zero = (ea_q == 8'h00);
    assign a_inf  = (ea_q == 8'hFF);
    assign b_zero = (eb_q == 8'h00);
    assign b_inf  = (eb_q == 8'hFF);

    // The first step compares the unshifted dividend so Q[8] is the integer bit of the ratio.
    assign shifted = (cnt_q == 4'd0) ? rem_q : {rem_q[7:0], 1'b0};
    assign diff    = {1'b0, shifted} - {2'b00, dvs_q};

    assign e_raw        = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
    assign e_norm       = q_q[8] ? e_raw : e_raw - 10'sd1;
    assign frac         = q_q[8] ? q_q[7:1] : q_q[6:0];
    assign frac_inexact = (q_q[8] & q_q[0]) | (rem_q != 9'd0);

    // DONE also samples start so back-to-back operations run at one per 11 cycles.
    assign accept = start && (state_q == IDLE || state_q == DONE);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        ea_d       = ea_q;
        eb_d       = eb_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        q_d        = q_q;
        quotient_d = quotient_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        inx_d      = inx_q;
        dbz_d      = dbz_q;

        if (state_q == DONE) begin
            state_d = IDLE;
        end

        if (accept) begin
            sign_d  = opA[15] ^ opB[15];
            ea_d    = opA[14:7];
            eb_d    = opB[14:7];
            rem_d   = {2'b01, opA[6:0]};
            dvs_d   = {1'b1, opB[6:0]};
            q_d     = 9'd0;
            cnt_d   = 4'd0;
            state_d = DIVIDE;
`ifdef FP_DIV_EARLY_OUT_EN
            // NORM overrides the result for special operands, so DIVIDE can be skipped.
            if (is_special(opA, opB)) begin
                state_d = NORM;
            end
`endif
        end else if (state_q == DIVIDE) begin
            q_d = {q_q[7:0], ~diff[9]};
            rem_d = diff[9] ? shifted : diff[8:0];
            if (cnt_q == 4'd8) begin
                cnt_d   = 4'd0;
                state_d = NORM;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else if (state_q == NORM) begin
            state_d = DONE;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            inx_d   = 1'b0;
            dbz_d   = 1'b0;
            if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                quotient_d = 16'h7FC0;
                dbz_d      = a_zero;
            end else if (b_zero) begin
                quotient_d = {sign_q, 8'hFF, 7'h00};
                dbz_d      = 1'b1;
            end else if (a_inf) begin
                quotient_d = {sign_q, 8'hFF, 7'h00};
                ovf_d      = 1'b1;
            end else if (a_zero || b_inf) begin
                quotient_d = {sign_q, 15'h0000};
            end else if (e_norm >= 10'sd255) begin
                quotient_d = {sign_q, 8'hFF, 7'h00};
                ovf_d      = 1'b1;
                inx_d      = frac_inexact;
            end else if (e_norm <= 10'sd0) begin
                quotient_d = {sign_q, 15'h0000};
                unf_d      = 1'b1;
                inx_d      = 1'b1;
            end else begin
                quotient_d = {sign_q, e_norm[7:0], frac};
                inx_d      = frac_inexact;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            sign_q     <= 1'b0;
            ea_q       <= 8'd0;
            eb_q       <= 8'd0;
            rem_q      <= 9'd0;
            dvs_q      <= 8'd0;
            q_q        <= 9'd0;
            quotient_q <= 16'd0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inx_q      <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            ea_q       <= ea_d;
            eb_q       <= eb_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            q_q        <= q_d;
            quotient_q <= quotient_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            inx_q      <= inx_d;
            dbz_q      <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign inexact     = inx_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_fp_div.sv
// Directed bench for fp_div: vector table with hand-computed results plus handshake/reset sequences.
// Expected special-operand latency follows FP_DIV_EARLY_OUT_EN.
module tb_fp_div;

`ifdef FP_DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 2;
`else
    localparam int SPECIAL_LAT = 11;
`endif
    localparam int NORMAL_LAT = 11;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] opA, opB;
    logic [15:0] quotient;
    logic        busy, done, overflow, underflow, inexact, div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    fp_div dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .opA         (opA),
        .opB         (opB),
        .quotient    (quotient),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .underflow   (underflow),
        .inexact     (inexact),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // flags are {overflow, underflow, inexact, div_by_zero}
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with done already low; returns the cycle count at which done was seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_div(input logic [15:0] a, input logic [15:0] b, output int lat);
        opA   = a;
        opB   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
    endtask

    function automatic logic [3:0] flags_now();
        return {overflow, underflow, inexact, div_by_zero};
    endfunction

    initial begin
        int  lat;
        bit  saw_done;

        vecs[0]  = '{16'h3F80, 16'h4000, 16'h3F00, 4'b0000, NORMAL_LAT};
        vecs[1]  = '{16'h3F80, 16'h4040, 16'h3EAA, 4'b0010, NORMAL_LAT};
        vecs[2]  = '{16'h4040, 16'h3FC0, 16'h4000, 4'b0000, NORMAL_LAT};
        vecs[3]  = '{16'hBF80, 16'h4000, 16'hBF00, 4'b0000, NORMAL_LAT};
        vecs[4]  = '{16'h3F80, 16'h0000, 16'h7F80, 4'b0001, SPECIAL_LAT};
        vecs[5]  = '{16'h0000, 16'h0000, 16'h7FC0, 4'b0001, SPECIAL_LAT};
        vecs[6]  = '{16'h7F00, 16'h0080, 16'h7F80, 4'b1000, NORMAL_LAT};
        vecs[7]  = '{16'h0080, 16'h7F00, 16'h0000, 4'b0110, NORMAL_LAT};
        vecs[8]  = '{16'h7F80, 16'h3F80, 16'h7F80, 4'b1000, SPECIAL_LAT};
        vecs[9]  = '{16'h7F80, 16'h7F80, 16'h7FC0, 4'b0000, SPECIAL_LAT};
        vecs[10] = '{16'h0000, 16'h4000, 16'h0000, 4'b0000, SPECIAL_LAT};
        vecs[11] = '{16'h4000, 16'h7F80, 16'h0000, 4'b0000, SPECIAL_LAT};
        vecs[12] = '{16'hC000, 16'h3F80, 16'hC000, 4'b0000, NORMAL_LAT};
        vecs[13] = '{16'h3F80, 16'h3FC0, 16'h3F2A, 4'b0010, NORMAL_LAT};

        reset = 1'b1;
        start = 1'b0;
        opA   = 16'h0000;
        opB   = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset quotient", {16'h0, quotient}, 32'h0);
        check("reset flags", {28'h0, flags_now()}, 32'h0);
        check("reset busy/done", {30'h0, busy, done}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            do_div(vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d quotient", i), {16'h0, quotient}, {16'h0, vecs[i].q});
            check($sformatf("v%0d flags", i), {28'h0, flags_now()}, {28'h0, vecs[i].flags});
            check($sformatf("v%0d latency", i), lat, vecs[i].lat);
            @(posedge clk);
            #1;
            check($sformatf("v%0d done pulse", i), {31'h0, done}, 32'h0);
            check($sformatf("v%0d busy fall", i), {31'h0, busy}, 32'h0);
        end

        // A start pulsed mid-divide must not disturb or queue a second operation.
        opA   = 16'h3F80;
        opB   = 16'h4000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("busy mid-divide", {31'h0, busy}, 32'h1);
        opA   = 16'h4040;
        opB   = 16'h3FC0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat++;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("ignore-start latency", lat, 11);
        check("ignore-start quotient", {16'h0, quotient}, 32'h3F00);
        saw_done = 1'b0;
        repeat (14) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("ignored start not queued", {31'h0, saw_done}, 32'h0);

        // Back-to-back: start held during the done cycle is accepted at that edge.
        do_div(16'h3F80, 16'h4000, lat);
        check("b2b first latency", lat, 11);
        opA   = 16'h4040;
        opB   = 16'h3FC0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b busy held", {31'h0, busy}, 32'h1);
        check("b2b done dropped", {31'h0, done}, 32'h0);
        wait_done(lat);
        check("b2b second latency", lat, 11);
        check("b2b second quotient", {16'h0, quotient}, 32'h4000);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a divide clears everything at once.
        opA   = 16'h3F80;
        opB   = 16'h4040;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async reset quotient", {16'h0, quotient}, 32'h0);
        check("async reset flags", {28'h0, flags_now()}, 32'h0);
        check("async reset busy/done", {30'h0, busy, done}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("no done after abort", {31'h0, saw_done}, 32'h0);
        do_div(16'h4000, 16'h4000, lat);
        check("post-reset latency", lat, 11);
        check("post-reset quotient", {16'h0, quotient}, 32'h3F80);
        check("post-reset flags", {28'h0, flags_now()}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
